// File: rtl/mure_pkg.sv
// Shared widths and entry types for the multiple-retirement serializer.
package mure_pkg;

  localparam int unsigned ITYPE_LEN = 3;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned CAUSE_LEN = 5;
  localparam int unsigned TVAL_LEN  = 32;
  localparam int unsigned PRIV_LEN  = 2;

  typedef struct packed {
    logic [ITYPE_LEN-1:0] itype;
    logic [XLEN-1:0]      iaddr;
    logic                 iretire;
    logic                 ilastsize;
  } uop_entry_s;

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [TVAL_LEN-1:0]  tval;
    logic [PRIV_LEN-1:0]  priv;
  } common_entry_s;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_LOAD,
    SER_EMIT
  } ser_state_e;

  // A slot carries trace information if it retired or reports a trap.
  function automatic logic slot_valid(input uop_entry_s uop);
    return uop.iretire | (uop.itype != '0);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Registered-output bundle FIFO; a push into a full FIFO is taken when a pop
// happens in the same cycle.
module fifo_v3 #(
  parameter int unsigned DEPTH = 16,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  dtype data_i,
  input  logic pop_i,
  output dtype data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dtype            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            full_q;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = full_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_q | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == (PtrW+1)'(DEPTH));
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which
  // entries are meaningful, so resetting the array would only cost area.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mure_serializer.sv
// Captures per-cycle commit bundles into a FIFO and replays their valid slots
// one per cycle, in port order, over a valid/ready handshake.
module mure_serializer
  import mure_pkg::*;
#(
  parameter int unsigned NrRetiredInstr = 2,
  parameter int unsigned FifoDepth      = 16,
  parameter int unsigned DropCntWidth   = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NrRetiredInstr-1:0]                iretire_i,
  input  logic [NrRetiredInstr-1:0]                ilastsize_i,
  input  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0] itype_i,
  input  logic [NrRetiredInstr-1:0][XLEN-1:0]      iaddr_i,
  input  logic [CAUSE_LEN-1:0]                     cause_i,
  input  logic [TVAL_LEN-1:0]                      tval_i,
  input  logic [PRIV_LEN-1:0]                      priv_i,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  output logic                                     iretire_o,
  output logic                                     ilastsize_o,
  output logic [ITYPE_LEN-1:0]                     itype_o,
  output logic [XLEN-1:0]                          iaddr_o,
  output logic [CAUSE_LEN-1:0]                     cause_o,
  output logic [TVAL_LEN-1:0]                      tval_o,
  output logic [PRIV_LEN-1:0]                      priv_o,
  output logic                                     last_o,
  output logic                                     full_o,
  output logic                                     overflow_o,
  output logic [DropCntWidth-1:0]                  drop_cnt_o
);

  localparam int unsigned IdxW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

  typedef struct packed {
    uop_entry_s [NrRetiredInstr-1:0] slots;
    common_entry_s                   common;
  } bundle_t;

  bundle_t                   bundle_in, head;
  logic [NrRetiredInstr-1:0] in_valid, head_valid;
  logic [NrRetiredInstr-1:0] cur_mask, mask_q, mask_d;
  logic                      loaded_q, loaded_d;
  logic                      fifo_full, fifo_empty;
  logic                      push, pop, drop, handshake;
  logic                      valid, last;
  logic [IdxW-1:0]           sel_idx;
  uop_entry_s                sel_uop;
  common_entry_s             sel_common;
  ser_state_e                state;
  logic [DropCntWidth-1:0]   drop_cnt_q;
  logic                      overflow_q;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    bundle_in  = '0;
    in_valid   = '0;
    head_valid = '0;
    for (int i = 0; i < int'(NrRetiredInstr); i++) begin
      bundle_in.slots[i].itype     = itype_i[i];
      bundle_in.slots[i].iaddr     = iaddr_i[i];
      bundle_in.slots[i].iretire   = iretire_i[i];
      bundle_in.slots[i].ilastsize = ilastsize_i[i];
      in_valid[i]   = slot_valid(bundle_in.slots[i]);
      head_valid[i] = slot_valid(head.slots[i]);
    end
    bundle_in.common.cause = cause_i;
    bundle_in.common.tval  = tval_i;
    bundle_in.common.priv  = priv_i;
  end

  assign push = |in_valid;
  assign pop  = handshake & last;
  assign drop = push & fifo_full & ~pop;

  fifo_v3 #(
    .DEPTH (FifoDepth),
    .dtype (bundle_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .push_i  (push),
    .data_i  (bundle_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q   <= '0;
      loaded_q <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      loaded_q <= loaded_d;
    end
  end

  // A fresh head is served straight from its slot flags so no bubble is lost.
  always_comb begin
    state     = SER_IDLE;
    cur_mask  = '0;
    sel_idx   = '0;
    mask_d    = mask_q;
    loaded_d  = loaded_q;
    if (!fifo_empty) state = loaded_q ? SER_EMIT : SER_LOAD;
    unique case (state)
      SER_LOAD: cur_mask = head_valid;
      SER_EMIT: cur_mask = mask_q;
      default:  cur_mask = '0;
    endcase
    valid     = (state != SER_IDLE);
    last      = valid && ((cur_mask & (cur_mask - NrRetiredInstr'(1))) == '0);
    handshake = valid & ready_i;
    for (int i = int'(NrRetiredInstr) - 1; i >= 0; i--) begin
      if (cur_mask[i]) sel_idx = IdxW'(i);
    end
    if (handshake) begin
      mask_d   = last ? '0 : (cur_mask & (cur_mask - NrRetiredInstr'(1)));
      loaded_d = ~last;
    end else if (state == SER_LOAD) begin
      mask_d   = cur_mask;
      loaded_d = 1'b1;
    end
  end

  // Data outputs read zero while idle so the unreset storage never leaks out.
  assign sel_uop    = valid ? head.slots[sel_idx] : '0;
  assign sel_common = valid ? head.common : '0;

  assign valid_o     = valid;
  assign last_o      = last;
  assign iretire_o   = sel_uop.iretire;
  assign ilastsize_o = sel_uop.ilastsize;
  assign itype_o     = sel_uop.itype;
  assign iaddr_o     = sel_uop.iaddr;
  assign cause_o     = sel_common.cause;
  assign tval_o      = sel_common.tval;
  assign priv_o      = sel_common.priv;
  assign full_o      = fifo_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_mure_serializer.sv
// Randomised and directed check of mure_serializer against a queue-based
// model of the uop stream it must produce.
module tb_mure_serializer;
  import mure_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int DMAX  = (1 << DW) - 1;

  logic                        clk_i = 1'b0;
  logic                        rst_i = 1'b0;
  logic [N-1:0]                iretire_i, ilastsize_i;
  logic [N-1:0][ITYPE_LEN-1:0] itype_i;
  logic [N-1:0][XLEN-1:0]      iaddr_i;
  logic [CAUSE_LEN-1:0]        cause_i;
  logic [TVAL_LEN-1:0]         tval_i;
  logic [PRIV_LEN-1:0]         priv_i;
  logic                        ready_i;
  logic                        valid_o, iretire_o, ilastsize_o, last_o;
  logic                        full_o, overflow_o;
  logic [ITYPE_LEN-1:0]        itype_o;
  logic [XLEN-1:0]             iaddr_o;
  logic [CAUSE_LEN-1:0]        cause_o;
  logic [TVAL_LEN-1:0]         tval_o;
  logic [PRIV_LEN-1:0]         priv_o;
  logic [DW-1:0]               drop_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mure_serializer #(
    .NrRetiredInstr (N),
    .FifoDepth      (DEPTH),
    .DropCntWidth   (DW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .iretire_i   (iretire_i),
    .ilastsize_i (ilastsize_i),
    .itype_i     (itype_i),
    .iaddr_i     (iaddr_i),
    .cause_i     (cause_i),
    .tval_i      (tval_i),
    .priv_i      (priv_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .iretire_o   (iretire_o),
    .ilastsize_o (ilastsize_o),
    .itype_o     (itype_o),
    .iaddr_o     (iaddr_o),
    .cause_o     (cause_o),
    .tval_o      (tval_o),
    .priv_o      (priv_o),
    .last_o      (last_o),
    .full_o      (full_o),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: one entry per uop still owed, plus a count of bundles held.
  typedef struct {
    logic [ITYPE_LEN-1:0] itype;
    logic [XLEN-1:0]      iaddr;
    logic                 iretire;
    logic                 ilastsize;
    logic [CAUSE_LEN-1:0] cause;
    logic [TVAL_LEN-1:0]  tval;
    logic [PRIV_LEN-1:0]  priv;
    bit                   last;
  } exp_uop_t;

  exp_uop_t exp_q[$];
  exp_uop_t m_u;
  int       m_bundles = 0;
  int       m_drop    = 0;
  bit       m_ovf     = 1'b0;
  int       m_n, m_k;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_q.delete();
      m_bundles = 0;
      m_drop    = 0;
      m_ovf     = 1'b0;
    end else begin
      if (exp_q.size() != 0 && ready_i) begin
        m_u = exp_q.pop_front();
        if (m_u.last) m_bundles--;
      end
      m_n = 0;
      for (int i = 0; i < N; i++) if (iretire_i[i] || itype_i[i] != 0) m_n++;
      if (m_n != 0) begin
        if (m_bundles < DEPTH) begin
          m_bundles++;
          m_k = 0;
          for (int i = 0; i < N; i++) begin
            if (iretire_i[i] || itype_i[i] != 0) begin
              m_u.itype     = itype_i[i];
              m_u.iaddr     = iaddr_i[i];
              m_u.iretire   = iretire_i[i];
              m_u.ilastsize = ilastsize_i[i];
              m_u.cause     = cause_i;
              m_u.tval      = tval_i;
              m_u.priv      = priv_i;
              m_u.last      = (m_k == m_n - 1);
              exp_q.push_back(m_u);
              m_k++;
            end
          end
        end else begin
          if (m_drop < DMAX) m_drop++;
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    check("valid", valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("iaddr", iaddr_o, exp_q[0].iaddr);
      check("itype", itype_o, exp_q[0].itype);
      check("iretire", iretire_o, exp_q[0].iretire);
      check("ilastsize", ilastsize_o, exp_q[0].ilastsize);
      check("cause", cause_o, exp_q[0].cause);
      check("tval", tval_o, exp_q[0].tval);
      check("priv", priv_o, exp_q[0].priv);
      check("last", last_o, exp_q[0].last);
    end
    check("full", full_o, m_bundles == DEPTH);
    check("overflow", overflow_o, m_ovf);
    check("drop_cnt", drop_cnt_o, m_drop);
  end

  task automatic drive(input logic [N-1:0] ret,
                       input logic [ITYPE_LEN-1:0] it1, input logic [ITYPE_LEN-1:0] it0,
                       input logic [XLEN-1:0] a1, input logic [XLEN-1:0] a0,
                       input logic [CAUSE_LEN-1:0] c, input logic [TVAL_LEN-1:0] tv,
                       input logic [PRIV_LEN-1:0] pv);
    iretire_i   = ret;
    itype_i[1]  = it1;
    itype_i[0]  = it0;
    iaddr_i[1]  = a1;
    iaddr_i[0]  = a0;
    ilastsize_i = N'($urandom);
    cause_i     = c;
    tval_i      = tv;
    priv_i      = pv;
  endtask

  task automatic idle();
    drive('0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    idle();
    ready_i = 1'b1;
    #1 rst_i = 1'b1;
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_last", last_o, 0);
    check("rst_full", full_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    check("rst_iaddr", iaddr_o, 0);
    check("rst_itype", itype_o, 0);
    check("rst_tval", tval_o, 0);
    check("rst_priv", priv_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Two-slot bundle, port order, shared priv.
    drive(2'b11, 0, 0, 32'h104, 32'h100, 0, 0, 3);
    @(negedge clk_i);
    idle();
    check("a_valid0", valid_o, 1);
    check("a_addr0", iaddr_o, 32'h100);
    check("a_last0", last_o, 0);
    check("a_priv0", priv_o, 3);
    @(negedge clk_i);
    check("a_addr1", iaddr_o, 32'h104);
    check("a_last1", last_o, 1);
    check("a_priv1", priv_o, 3);
    @(negedge clk_i);
    check("a_done", valid_o, 0);

    // Only the upper slot valid.
    drive(2'b10, 0, 0, 32'h200, 32'h0, 0, 0, 0);
    @(negedge clk_i);
    idle();
    check("b_valid", valid_o, 1);
    check("b_addr", iaddr_o, 32'h200);
    check("b_last", last_o, 1);
    repeat (3) begin
      @(negedge clk_i);
      check("b_quiet", valid_o, 0);
    end

    // Trap report without retirement.
    drive(2'b00, 0, 1, 0, 32'h300, 2, 32'hdead, 0);
    @(negedge clk_i);
    idle();
    check("x_itype", itype_o, 1);
    check("x_iretire", iretire_o, 0);
    check("x_cause", cause_o, 2);
    check("x_tval", tval_o, 32'hdead);
    check("x_last", last_o, 1);
    @(negedge clk_i);
    check("x_done", valid_o, 0);

    // Stall for 20 cycles while 18 bundles arrive: two are dropped.
    ready_i = 1'b0;
    for (int k = 0; k < 18; k++) begin
      drive(2'b11, 0, 0, 32'h1000 + 8*k + 4, 32'h1000 + 8*k, 0, 0, 1);
      @(negedge clk_i);
    end
    idle();
    repeat (2) @(negedge clk_i);
    check("o_full", full_o, 1);
    check("o_drop", drop_cnt_o, 2);
    check("o_overflow", overflow_o, 1);
    for (int j = 0; j < 32; j++) begin
      check("o_stream_valid", valid_o, 1);
      check("o_stream_addr", iaddr_o, 32'h1000 + 4*j);
      ready_i = 1'b1;
      @(negedge clk_i);
    end
    check("o_drained", valid_o, 0);
    check("o_notfull", full_o, 0);

    // Full FIFO with a pop every cycle accepts the simultaneous push.
    ready_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive(2'b01, 0, 0, 0, 32'h2000 + 4*k, 0, 0, 0);
      @(negedge clk_i);
    end
    check("p_full", full_o, 1);
    ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(2'b01, 0, 0, 0, 32'h3000 + 4*k, 0, 0, 0);
      @(negedge clk_i);
      check("p_full_hold", full_o, 1);
      check("p_drop_hold", drop_cnt_o, 2);
    end
    idle();
    repeat (20) @(negedge clk_i);
    check("p_drained", valid_o, 0);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 1500; c++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      drive(N'($urandom),
            ($urandom_range(0, 7) == 0) ? ITYPE_LEN'($urandom) : '0,
            ($urandom_range(0, 7) == 0) ? ITYPE_LEN'($urandom) : '0,
            $urandom, $urandom, CAUSE_LEN'($urandom), $urandom, PRIV_LEN'($urandom));
      @(negedge clk_i);
    end
    idle();
    ready_i = 1'b1;
    repeat (40) @(negedge clk_i);

    // Long stall saturates the drop counter.
    ready_i = 1'b0;
    repeat (300) begin
      drive(2'b11, 0, 0, $urandom, $urandom, 0, 0, 0);
      @(negedge clk_i);
    end
    idle();
    check("s_drop_sat", drop_cnt_o, DMAX);
    check("s_overflow", overflow_o, 1);
    ready_i = 1'b1;
    repeat (40) @(negedge clk_i);

    // Reset between the two uops of a bundle discards everything.
    drive(2'b11, 0, 0, 32'h504, 32'h500, 0, 0, 0);
    @(negedge clk_i);
    idle();
    check("r_first", iaddr_o, 32'h500);
    #1 rst_i = 1'b1;
    #1;
    check("r_valid", valid_o, 0);
    check("r_last", last_o, 0);
    check("r_drop", drop_cnt_o, 0);
    check("r_overflow", overflow_o, 0);
    check("r_iaddr", iaddr_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      check("r_quiet", valid_o, 0);
      check("r_drop_zero", drop_cnt_o, 0);
      check("r_full_zero", full_o, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
